// File: rtl/mem_responder.sv
// mem_responder: LC-3b target-side memory model with byte-enable writes and fixed response latency
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   mem_read        read request, held until mem_resp
//   mem_write       write request, held until mem_resp (wins over mem_read)
//   mem_address     byte address, word index = mem_address[$clog2(WORDS):1]
//   mem_wdata       write data
//   mem_byte_enable [0] -> bits 7:0, [1] -> bits 15:8, writes only
//   mem_rdata       read data, valid while mem_resp is high for a read
//   mem_resp        one-cycle completion pulse
//   mem_busy        high while a request is in flight (WAIT or RESP)
module mem_responder #(
  parameter int WORDS   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_busy
);
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wr;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_wdata;
  logic [1:0]    r_be;
  logic [15:0]   r_rdata;
  logic [15:0]   r_mem [WORDS];
  logic [IW-1:0] w_idx;
  logic          w_req;
  logic          w_live;
  logic          w_unused;
  assign w_idx    = mem_address[IW:1];
  assign w_req    = mem_read | mem_write;
  // the request line of the latched op must stay high through WAIT, else the request is abandoned
  assign w_live   = r_wr ? mem_write : mem_read;
  assign w_unused = ^mem_address;
  assign mem_rdata = r_rdata;
  assign mem_resp  = r_state == S_RESP;
  assign mem_busy  = r_state != S_IDLE;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_wr    <= mem_write;
          r_idx   <= w_idx;
          r_wdata <= mem_wdata;
          r_be    <= mem_byte_enable;
          r_cnt   <= CW'(LATENCY - 1);
          r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          // with single-cycle latency RESP is entered straight from IDLE, so read from the live index
          if (LATENCY == 1 && !mem_write) r_rdata <= r_mem[w_idx];
        end
        S_WAIT: if (!w_live) begin
          r_state <= S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          r_state <= S_RESP;
          if (!r_wr) r_rdata <= r_mem[r_idx];
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // array is not reset; a write commits on the edge leaving RESP, so a reset during WAIT drops it
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_wr) begin
      if (r_be[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
      if (r_be[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder at latencies 3, 1 and 5
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] mem_address = '0, mem_wdata = '0;
  logic [1:0]  mem_byte_enable = '0;
  logic [15:0] mem_rdata;
  logic        mem_resp, mem_busy;
  logic        rd1 = 1'b0, rd5 = 1'b0, wr0 = 1'b0;
  logic [15:0] a0 = '0, d0 = '0;
  logic [1:0]  b0 = '0;
  logic [15:0] q1, q5;
  logic        resp1, resp5, busy1, busy5;
  int          cmp = 0, fails = 0;
  int          n, f1, f5, c1, c5;
  logic [15:0] q;
  logic        af;

  always #5 clk = ~clk;

  mem_responder #(.WORDS(256), .LATENCY(3)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .mem_busy(mem_busy));

  mem_responder #(.WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd1), .mem_write(wr0),
    .mem_address(a0), .mem_wdata(d0), .mem_byte_enable(b0),
    .mem_rdata(q1), .mem_resp(resp1), .mem_busy(busy1));

  mem_responder #(.WORDS(256), .LATENCY(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .mem_read(rd5), .mem_write(wr0),
    .mem_address(a0), .mem_wdata(d0), .mem_byte_enable(b0),
    .mem_rdata(q5), .mem_resp(resp5), .mem_busy(busy5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // issue one request, count cycles until mem_resp, then drop it and sample one cycle later
  task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] b, output int cyc, output logic [15:0] rd, output logic after);
    mem_read = r; mem_write = w; mem_address = a; mem_wdata = d; mem_byte_enable = b;
    cyc = 0;
    do begin tick(); cyc++; end while (mem_resp !== 1'b1 && cyc < 20);
    rd = mem_rdata;
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    after = mem_resp;
  endtask

  initial begin
    #12;
    chk("rst_resp", {31'b0, mem_resp}, 32'd0);
    chk("rst_busy", {31'b0, mem_busy}, 32'd0);
    chk("rst_rdata", {16'b0, mem_rdata}, 32'h0);
    reset_n = 1'b1;
    tick();

    rd1 = 1'b1; rd5 = 1'b1;
    f1 = 0; f5 = 0; c1 = 0; c5 = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (resp1) begin if (f1 == 0) f1 = t; c1++; rd1 = 1'b0; end
      if (resp5) begin if (f5 == 0) f5 = t; c5++; rd5 = 1'b0; end
    end
    chk("lat1_first", f1, 1);
    chk("lat1_width", c1, 1);
    chk("lat5_first", f5, 5);
    chk("lat5_width", c5, 1);

    req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, n, q, af);
    chk("wr_lat", n, 3);
    chk("wr_width", {31'b0, af}, 0);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, n, q, af);
    chk("rd_lat", n, 3);
    chk("rd_beef", {16'b0, q}, 32'hBEEF);
    chk("rd_width", {31'b0, af}, 0);

    req(1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, n, q, af);
    req(1'b0, 1'b1, 16'h0020, 16'hABCD, 2'b01, n, q, af);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, n, q, af);
    chk("be01", {16'b0, q}, 32'h12CD);
    req(1'b0, 1'b1, 16'h0020, 16'hABCD, 2'b10, n, q, af);
    req(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, n, q, af);
    chk("be10", {16'b0, q}, 32'hABCD);
    req(1'b0, 1'b1, 16'h0020, 16'h0000, 2'b00, n, q, af);
    chk("be00_lat", n, 3);
    req(1'b1, 1'b0, 16'h0020, 16'hFFFF, 2'b11, n, q, af);
    chk("be00_keep", {16'b0, q}, 32'hABCD);

    req(1'b0, 1'b1, 16'h0030, 16'h7777, 2'b11, n, q, af);
    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h5555; mem_byte_enable = 2'b11;
    tick();
    chk("abort_busy", {31'b0, mem_busy}, 1);
    mem_write = 1'b0;
    tick();
    chk("abort_idle", {31'b0, mem_busy}, 0);
    c1 = 0;
    for (int t = 0; t < 4; t++) begin
      if (mem_resp) c1++;
      tick();
    end
    chk("abort_noresp", c1, 0);
    chk("abort_rdata", {16'b0, mem_rdata}, 32'hABCD);
    req(1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, n, q, af);
    chk("abort_keep", {16'b0, q}, 32'h7777);

    req(1'b0, 1'b1, 16'h0201, 16'h0F0F, 2'b11, n, q, af);
    req(1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, n, q, af);
    chk("wrap", {16'b0, q}, 32'h0F0F);

    mem_write = 1'b1; mem_address = 16'h0040; mem_wdata = 16'h2222; mem_byte_enable = 2'b11;
    tick();
    mem_address = 16'h0050; mem_wdata = 16'h9999; mem_byte_enable = 2'b00;
    n = 1;
    while (mem_resp !== 1'b1 && n < 20) begin tick(); n++; end
    chk("latch_lat", n, 3);
    mem_write = 1'b0;
    tick();
    req(1'b1, 1'b1, 16'h0050, 16'h3333, 2'b11, n, q, af);
    req(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, n, q, af);
    chk("latched", {16'b0, q}, 32'h2222);
    req(1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, n, q, af);
    chk("wr_prio", {16'b0, q}, 32'h3333);

    mem_write = 1'b1; mem_address = 16'h0010; mem_wdata = 16'h6666; mem_byte_enable = 2'b11;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_resp", {31'b0, mem_resp}, 0);
    chk("arst_busy", {31'b0, mem_busy}, 0);
    chk("arst_rdata", {16'b0, mem_rdata}, 32'h0);
    mem_write = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    req(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, n, q, af);
    chk("arst_nowrite", {16'b0, q}, 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
